// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the sequential ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// o_lo/o_hi present the post-step values so the last step can be captured directly.
module seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_step_done
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_div;
    logic [CNTW-1:0]  r_cnt;

    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;

    always_comb begin
        w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        // Partial remainder is always below the divisor, so the difference fits WIDTH bits
        w_rem  = {r_hi, r_lo[WIDTH-1]};
        w_diff = w_rem[WIDTH-1:0] - r_b;
        w_ge   = (w_rem >= {1'b0, r_b});
        w_hi_n = w_madd[WIDTH:1];
        w_lo_n = {w_madd[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            w_hi_n = w_ge ? w_diff : w_rem[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    assign o_lo        = w_lo_n;
    assign o_hi        = w_hi_n;
    assign o_step_done = i_step && (r_cnt == CNTW'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_is_div ? i_a : i_b;
            r_b   <= i_is_div ? i_b : i_a;
            r_div <= i_is_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential 16-bit ALU feeding the accumulator: FSM, single-cycle datapath,
// and result/flag registers that hold until the next completed operation.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = 4,
    parameter int CNTW  = 5
) (
    input  logic             clk_50m,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] aux_out,
    output logic             acc_wr_en,
    output logic             done,
    output logic             busy,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_dz
);

    state_t           r_state;
    state_t           w_nxt;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_aux;
    logic             r_z;
    logic             r_c;
    logic             r_dz;
    logic             r_wr;

    logic             w_load;
    logic             w_cap_s;
    logic             w_cap_m;
    logic             w_iter;

    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_aux;
    logic             w_c;
    logic             w_dz;
    logic             w_valid;

    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;
    logic             w_md_last;

    seq_muldiv #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_muldiv (
        .i_clk       (clk_50m),
        .i_rst_n     (reset_n),
        .i_load      (w_load),
        .i_step      (r_state == ST_RUN),
        .i_is_div    (opcode == OP_DIV),
        .i_a         (a_in),
        .i_b         (b_in),
        .o_lo        (w_md_lo),
        .o_hi        (w_md_hi),
        .o_step_done (w_md_last)
    );

    always_comb begin
        w_wide  = '0;
        w_res   = '0;
        w_aux   = '0;
        w_c     = 1'b0;
        w_dz    = 1'b0;
        w_valid = 1'b1;
        case (opcode)
            OP_PASSB: w_res = b_in;
            OP_ADD: begin
                w_wide = {1'b0, a_in} + {1'b0, b_in};
                {w_c, w_res} = w_wide;
            end
            OP_SUB: begin
                w_wide = {1'b0, a_in} - {1'b0, b_in};
                {w_c, w_res} = w_wide;
            end
            OP_AND: w_res = a_in & b_in;
            OP_OR:  w_res = a_in | b_in;
            OP_XOR: w_res = a_in ^ b_in;
            OP_NOT: w_res = ~a_in;
            OP_SHL: begin
                w_res = {a_in[WIDTH-2:0], 1'b0};
                w_c   = a_in[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, a_in[WIDTH-1:1]};
                w_c   = a_in[0];
            end
            OP_INC: begin
                w_wide = {1'b0, a_in} + 1'b1;
                {w_c, w_res} = w_wide;
            end
            OP_DEC: begin
                w_wide = {1'b0, a_in} - 1'b1;
                {w_c, w_res} = w_wide;
            end
            // Only the divide-by-zero case of DIV completes in one cycle
            OP_DIV: begin
                w_res = '1;
                w_aux = a_in;
                w_dz  = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
    end

    assign w_iter = (opcode == OP_MUL) ||
                    ((opcode == OP_DIV) && (b_in != '0));

    always_comb begin
        w_nxt   = r_state;
        w_load  = 1'b0;
        w_cap_s = 1'b0;
        w_cap_m = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_iter) begin
                        w_nxt  = ST_RUN;
                        w_load = 1'b1;
                    end else begin
                        w_nxt   = ST_DONE;
                        w_cap_s = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_md_last) begin
                    w_nxt   = ST_DONE;
                    w_cap_m = 1'b1;
                end
            end
            ST_DONE: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            r_op  <= '0;
            r_out <= '0;
            r_aux <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_dz  <= 1'b0;
            r_wr  <= 1'b0;
        end else begin
            if (w_load) begin
                r_op <= opcode;
            end
            if (w_cap_s) begin
                r_op <= opcode;
                r_wr <= w_valid;
                if (w_valid) begin
                    r_out <= w_res;
                    r_aux <= w_aux;
                    r_z   <= (w_res == '0);
                    r_c   <= w_c;
                    r_dz  <= w_dz;
                end
            end
            if (w_cap_m) begin
                r_wr  <= 1'b1;
                r_out <= w_md_lo;
                r_z   <= (w_md_lo == '0);
                r_dz  <= 1'b0;
                if (r_op == OP_DIV) begin
                    r_aux <= w_md_hi;
                    r_c   <= 1'b0;
                end else begin
                    r_aux <= '0;
                    r_c   <= (w_md_hi != '0);
                end
            end
        end
    end

    assign alu_out   = r_out;
    assign aux_out   = r_aux;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_dz   = r_dz;
    assign done      = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign acc_wr_en = done && r_wr;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq.
module tb_alu_seq;

    logic        clk_50m = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [3:0]  opcode  = 4'd0;
    logic [15:0] a_in    = 16'd0;
    logic [15:0] b_in    = 16'd0;
    logic [15:0] alu_out;
    logic [15:0] aux_out;
    logic        acc_wr_en;
    logic        done;
    logic        busy;
    logic        flag_z;
    logic        flag_c;
    logic        flag_dz;

    int n_chk = 0;
    int n_err = 0;

    alu_seq dut (
        .clk_50m   (clk_50m),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .a_in      (a_in),
        .b_in      (b_in),
        .alu_out   (alu_out),
        .aux_out   (aux_out),
        .acc_wr_en (acc_wr_en),
        .done      (done),
        .busy      (busy),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_dz   (flag_dz)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the done cycle; lat counts cycles since the start edge.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, output int lat);
        int g;
        g = 0;
        while (busy && g < 40) begin
            tick();
            g++;
        end
        opcode = op;
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int nwr;
        int dcyc;

        tick();
        tick();
        chk("rst_out", {aux_out, alu_out}, 32'h0);
        chk("rst_ctl", {acc_wr_en, done, busy, flag_z, flag_c, flag_dz}, 32'h0);
        reset_n = 1'b1;
        tick();

        run_op(4'd1, 16'hFFFF, 16'h0001, lat);
        chk("add_lat", lat, 1);
        chk("add_ctl", {done, acc_wr_en, busy}, 3'b111);
        chk("add_out", alu_out, 16'h0000);
        chk("add_flg", {flag_z, flag_c, flag_dz}, 3'b110);
        tick();
        chk("add_idle", {busy, done, acc_wr_en}, 3'b000);

        run_op(4'd11, 16'd300, 16'd200, lat);
        chk("mul1_lat", lat, 17);
        chk("mul1_out", {aux_out, alu_out}, 32'h0000_EA60);
        chk("mul1_flg", {flag_z, flag_c, flag_dz, acc_wr_en}, 4'b0001);

        run_op(4'd11, 16'h0100, 16'h0100, lat);
        chk("mul2_lat", lat, 17);
        chk("mul2_out", alu_out, 16'h0000);
        chk("mul2_flg", {flag_z, flag_c}, 2'b11);

        run_op(4'd12, 16'd1000, 16'd7, lat);
        chk("div1_lat", lat, 17);
        chk("div1_out", {aux_out, alu_out}, 32'h0006_008E);
        chk("div1_flg", {flag_z, flag_c, flag_dz, acc_wr_en}, 4'b0001);

        run_op(4'd12, 16'h1234, 16'h0000, lat);
        chk("divz_lat", lat, 1);
        chk("divz_out", {aux_out, alu_out}, 32'h1234_FFFF);
        chk("divz_flg", {flag_dz, acc_wr_en, flag_c}, 3'b110);
        tick();

        // MUL 0x1234*3 with ignored SUB restarts and a changing a_in
        opcode = 4'd11;
        a_in   = 16'h1234;
        b_in   = 16'h0003;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ndone  = 0;
        nwr    = 0;
        dcyc   = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                ndone++;
                dcyc = c;
            end
            if (acc_wr_en) nwr++;
            opcode = 4'd2;
            if (c == 5) a_in = 16'h5555;
            if (c == 12) b_in = 16'h0009;
            start = (c == 3) || (c == 10);
            tick();
            start = 1'b0;
        end
        chk("busy_ndone", ndone, 1);
        chk("busy_nwr", nwr, 1);
        chk("busy_dcyc", dcyc, 17);
        chk("busy_out", alu_out, 16'h369C);

        // Abort a DIV at cycle 8
        opcode = 4'd12;
        a_in   = 16'd1000;
        b_in   = 16'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_out", {aux_out, alu_out}, 32'h0);
        chk("abort_ctl", {acc_wr_en, done, busy, flag_z, flag_c, flag_dz}, 32'h0);
        ndone = 0;
        nwr   = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            if (acc_wr_en) nwr++;
            tick();
        end
        chk("abort_nodone", ndone + nwr, 0);
        run_op(4'd1, 16'd2, 16'd3, lat);
        chk("abort_add", {lat[7:0], alu_out}, {8'd1, 16'd5});

        run_op(4'd2, 16'd3, 16'd5, lat);
        chk("sub_out", alu_out, 16'hFFFE);
        chk("sub_flg", {flag_z, flag_c}, 2'b01);

        run_op(4'd8, 16'h0001, 16'h0000, lat);
        chk("shr_out", alu_out, 16'h0000);
        chk("shr_flg", {flag_z, flag_c}, 2'b11);

        run_op(4'd7, 16'h8001, 16'h0000, lat);
        chk("shl_out", {alu_out, 14'd0, flag_z, flag_c}, {16'h0002, 16'h0001});

        run_op(4'd10, 16'h0000, 16'h0000, lat);
        chk("dec_out", {alu_out, 15'd0, flag_c}, {16'hFFFF, 16'h0001});

        run_op(4'd14, 16'h7777, 16'h8888, lat);
        chk("rsv_lat", lat, 1);
        chk("rsv_ctl", {done, acc_wr_en}, 2'b10);
        chk("rsv_hold", {alu_out, aux_out}, 32'hFFFF_0000);
        chk("rsv_flg", {flag_z, flag_c, flag_dz}, 3'b010);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
